// File: rtl/scan_pkg.sv
// Shared definitions for the multiplexed digit scan controller:
// FSM state encoding, default phase lengths and a width helper.
package scan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHOW  = 2'b01,
      ST_BLANK = 2'b10
   } scan_state_t;

   localparam int DIV_DEFAULT   = 12000;
   localparam int BLANK_DEFAULT = 64;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Phase counter shared by the SHOW and BLANK phases: synchronous clear,
// free count otherwise, terminal-count flag against a supplied terminal value.
module scan_prescaler #(
   parameter int W = 14
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic [W-1:0] term,
   output logic         tc
);

   logic [W-1:0] count;

   // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else begin
         count <= count + W'(1);
      end
   end

   assign tc = (count == term);

endmodule

// File: rtl/digit_scan_ctrl.sv
// Four-digit multiplexed display scanner: SHOW/BLANK timing per digit,
// per-digit masking and tear-free (frame-aligned) digit updates.
module digit_scan_ctrl
   import scan_pkg::*;
#(
   parameter int DIV   = DIV_DEFAULT,
   parameter int BLANK = BLANK_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic        load,
   input  logic [15:0] digits_in,
   input  logic [3:0]  digit_mask,
   output logic        a0,
   output logic        a1,
   output logic        en,
   output logic [3:0]  nibble,
   output logic        frame_tick
);

   localparam int            PW         = $clog2(max_int(DIV, BLANK));
   localparam logic [PW-1:0] SHOW_TERM  = PW'(DIV - 1);
   localparam logic [PW-1:0] BLANK_TERM = PW'(BLANK - 1);

   scan_state_t   state, state_nxt;
   logic [1:0]    idx, idx_nxt;
   logic [15:0]   shadow, shadow_nxt;
   logic [15:0]   active, active_nxt;
   logic          pending, pending_nxt;
   logic          phase_tc, phase_clr, frame_bnd;
   logic [PW-1:0] phase_term;

   assign phase_term = (state == ST_SHOW) ? SHOW_TERM : BLANK_TERM;

   scan_prescaler #(.W(PW)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (phase_clr),
      .term (phase_term),
      .tc   (phase_tc)
   );

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      if (!run) begin
         state_nxt = ST_IDLE;
         idx_nxt   = 2'd0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               state_nxt = ST_SHOW;
               idx_nxt   = 2'd0;
            end
            ST_SHOW: begin
               if (phase_tc) state_nxt = ST_BLANK;
            end
            ST_BLANK: begin
               if (phase_tc) begin
                  state_nxt = ST_SHOW;
                  idx_nxt   = idx + 2'd1;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               idx_nxt   = 2'd0;
            end
         endcase
      end
      // Prescaler restarts on every phase change and stays parked while idle.
      phase_clr = (state_nxt != state) || (state_nxt == ST_IDLE);
      frame_bnd = run && (state == ST_BLANK) && (idx == 2'd3) && phase_tc;
   end

   // Digit data path: new values wait in shadow until a frame boundary or idle.
   always_comb begin
      shadow_nxt  = shadow;
      active_nxt  = active;
      pending_nxt = pending;
      if (frame_bnd) begin
         if (load) begin
            active_nxt  = digits_in;
            pending_nxt = 1'b0;
         end else if (pending) begin
            active_nxt  = shadow;
            pending_nxt = 1'b0;
         end
      end else begin
         if (state == ST_IDLE && pending) begin
            active_nxt  = shadow;
            pending_nxt = 1'b0;
         end
         if (load) begin
            shadow_nxt  = digits_in;
            pending_nxt = 1'b1;
         end
      end
   end

   // Outputs are registered from the next-state values so they line up with the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         idx        <= 2'd0;
         shadow     <= '0;
         active     <= '0;
         pending    <= 1'b0;
         a0         <= 1'b0;
         a1         <= 1'b0;
         en         <= 1'b0;
         nibble     <= 4'd0;
         frame_tick <= 1'b0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         shadow     <= shadow_nxt;
         active     <= active_nxt;
         pending    <= pending_nxt;
         a0         <= idx_nxt[0];
         a1         <= idx_nxt[1];
         en         <= (state_nxt == ST_SHOW) && !digit_mask[idx_nxt];
         nibble     <= active_nxt[{idx_nxt, 2'b00} +: 4];
         frame_tick <= frame_bnd;
      end
   end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Self-checking bench for digit_scan_ctrl (DIV=4, BLANK=2): directed scenarios
// plus randomized traffic compared every cycle against a time-based model.
module tb_digit_scan_ctrl;

   localparam int D  = 4;
   localparam int B  = 2;
   localparam int P  = D + B;
   localparam int FR = 4 * P;

   logic        clk;
   logic        rst;
   logic        run;
   logic        load;
   logic [15:0] digits_in;
   logic [3:0]  digit_mask;
   logic        a0, a1, en, frame_tick;
   logic [3:0]  nibble;

   int checks   = 0;
   int failures = 0;
   bit cmp_on   = 1'b0;

   digit_scan_ctrl #(.DIV(D), .BLANK(B)) dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .load       (load),
      .digits_in  (digits_in),
      .digit_mask (digit_mask),
      .a0         (a0),
      .a1         (a1),
      .en         (en),
      .nibble     (nibble),
      .frame_tick (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic reset_dut();
      rst        = 1'b1;
      run        = 1'b0;
      load       = 1'b0;
      digits_in  = 16'h0;
      digit_mask = 4'h0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Behavioural model: position inside the scan is derived from elapsed cycles.
   bit          m_scan;
   int          m_t;
   logic [15:0] m_shadow, m_active;
   bit          m_pending;
   logic        exp_en, exp_ft;
   logic [1:0]  exp_idx;
   logic [3:0]  exp_nib;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_scan = 0; m_t = 0; m_shadow = '0; m_active = '0; m_pending = 0;
         exp_en = 0; exp_ft = 0; exp_idx = '0; exp_nib = '0;
      end else begin
         bit bnd;
         int pos;
         bnd = 0;
         if (!m_scan) begin
            if (m_pending) begin m_active = m_shadow; m_pending = 0; end
            if (load) begin m_shadow = digits_in; m_pending = 1; end
            if (run) begin m_scan = 1; m_t = 0; end
         end else if (!run) begin
            m_scan = 0;
            if (load) begin m_shadow = digits_in; m_pending = 1; end
         end else begin
            m_t++;
            bnd = (m_t % FR) == 0;
            if (bnd && load) begin m_active = digits_in; m_pending = 0; end
            else if (bnd && m_pending) begin m_active = m_shadow; m_pending = 0; end
            else if (!bnd && load) begin m_shadow = digits_in; m_pending = 1; end
         end
         if (m_scan) begin
            pos     = m_t % FR;
            exp_idx = 2'(pos / P);
            exp_en  = ((pos % P) < D) && !digit_mask[exp_idx];
            exp_ft  = bnd;
         end else begin
            exp_idx = 2'd0;
            exp_en  = 1'b0;
            exp_ft  = 1'b0;
         end
         exp_nib = m_active[{exp_idx, 2'b00} +: 4];
      end
   end

   always @(negedge clk) begin
      if (cmp_on && !rst) begin
         check("model_en",     32'(en),         32'(exp_en));
         check("model_a1a0",   32'({a1, a0}),   32'(exp_idx));
         check("model_nibble", 32'(nibble),     32'(exp_nib));
         check("model_ftick",  32'(frame_tick), 32'(exp_ft));
      end
   end

   initial begin
      int ft_cnt;
      rst = 1'b1; run = 1'b0; load = 1'b0; digits_in = '0; digit_mask = '0;
      reset_dut();
      cmp_on = 1'b1;

      check("rst_en",     32'(en),         32'd0);
      check("rst_a1a0",   32'({a1, a0}),   32'd0);
      check("rst_nibble", 32'(nibble),     32'd0);
      check("rst_ftick",  32'(frame_tick), 32'd0);

      // Scan timing from a fresh start.
      ft_cnt = 0;
      run = 1'b1;
      for (int c = 1; c <= 25; c++) begin
         tick();
         if (c < 25) ft_cnt += int'(frame_tick);
         case (c)
            1:  begin check("t1_en_c1", 32'(en), 32'd1); check("t1_a_c1", 32'({a1, a0}), 32'd0); end
            4:  check("t1_en_c4", 32'(en), 32'd1);
            5:  check("t1_en_c5", 32'(en), 32'd0);
            6:  begin check("t1_en_c6", 32'(en), 32'd0); check("t1_a_c6", 32'({a1, a0}), 32'd0); end
            7:  begin check("t1_en_c7", 32'(en), 32'd1); check("t1_a_c7", 32'({a1, a0}), 32'd1); end
            10: check("t1_en_c10", 32'(en), 32'd1);
            25: check("t1_ft_c25", 32'(frame_tick), 32'd1);
            default: ;
         endcase
      end
      check("t1_ft_early", 32'(ft_cnt), 32'd0);

      // Tear-free update.
      reset_dut();
      digits_in = 16'h4321; load = 1'b1; tick(); load = 1'b0; tick();
      run = 1'b1;
      for (int c = 1; c <= 31; c++) begin
         load      = (c == 10);
         digits_in = (c == 10) ? 16'hABCD : 16'h0000;
         tick();
         case (c)
            1:  check("t2_nib_c1",  32'(nibble), 32'h1);
            7:  check("t2_nib_c7",  32'(nibble), 32'h2);
            13: check("t2_nib_c13", 32'(nibble), 32'h3);
            19: check("t2_nib_c19", 32'(nibble), 32'h4);
            25: check("t2_nib_c25", 32'(nibble), 32'hD);
            31: check("t2_nib_c31", 32'(nibble), 32'hC);
            default: ;
         endcase
      end
      load = 1'b0;

      // Load coincident with the frame boundary.
      reset_dut();
      run = 1'b1;
      for (int c = 1; c <= 25; c++) begin
         load      = (c == 25);
         digits_in = (c == 25) ? 16'h5555 : 16'h0000;
         tick();
         if (c == 24) check("t3_nib_c24", 32'(nibble), 32'h0);
         if (c == 25) begin
            check("t3_nib_c25", 32'(nibble), 32'h5);
            check("t3_ft_c25",  32'(frame_tick), 32'd1);
            check("t3_pending", 32'(dut.pending), 32'd0);
         end
      end
      load = 1'b0;

      // Masking keeps the period.
      reset_dut();
      digit_mask = 4'b0100;
      run = 1'b1;
      for (int c = 1; c <= 25; c++) begin
         tick();
         case (c)
            13: begin check("t4_en_c13", 32'(en), 32'd0); check("t4_a_c13", 32'({a1, a0}), 32'd2); end
            16: check("t4_en_c16", 32'(en), 32'd0);
            18: check("t4_a_c18",  32'({a1, a0}), 32'd2);
            19: begin check("t4_en_c19", 32'(en), 32'd1); check("t4_a_c19", 32'({a1, a0}), 32'd3); end
            25: check("t4_ft_c25", 32'(frame_tick), 32'd1);
            default: ;
         endcase
      end
      digit_mask = 4'b0000;

      // Stop during index-2 SHOW, then restart.
      reset_dut();
      for (int c = 1; c <= 22; c++) begin
         run = !(c == 15 || c == 16);
         tick();
         case (c)
            14: begin check("t5_en_c14", 32'(en), 32'd1); check("t5_a_c14", 32'({a1, a0}), 32'd2); end
            15: begin check("t5_en_c15", 32'(en), 32'd0); check("t5_a_c15", 32'({a1, a0}), 32'd0); end
            17: begin check("t5_en_c17", 32'(en), 32'd1); check("t5_a_c17", 32'({a1, a0}), 32'd0); end
            20: check("t5_en_c20", 32'(en), 32'd1);
            21: check("t5_en_c21", 32'(en), 32'd0);
            default: ;
         endcase
      end

      // Asynchronous reset in the middle of SHOW.
      reset_dut();
      digits_in = 16'h4321; load = 1'b1; tick(); load = 1'b0; tick();
      run = 1'b1;
      tick(); tick();
      check("t6_en_pre",  32'(en),     32'd1);
      check("t6_nib_pre", 32'(nibble), 32'h1);
      #2 rst = 1'b1;
      #1;
      check("t6_en_async",     32'(en),         32'd0);
      check("t6_ft_async",     32'(frame_tick), 32'd0);
      check("t6_a_async",      32'({a1, a0}),   32'd0);
      check("t6_nib_async",    32'(nibble),     32'd0);
      check("t6_active_async", 32'(dut.active), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run = 1'b0;

      // Randomized traffic; the compare process checks every cycle.
      for (int i = 0; i < 3000; i++) begin
         run  = ($urandom_range(0, 99) >= 4);
         load = ($urandom_range(0, 9) == 0);
         digits_in = 16'($urandom);
         if ($urandom_range(0, 19) == 0) digit_mask = 4'($urandom);
         if ($urandom_range(0, 999) == 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
